// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq command sequencer: default widths,
// FSM state encoding and bit positions inside the 6-bit ALU control word.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int CTRL_W     = 6;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_CAP_A = 3'd2,
        S_RD_B  = 3'd3,
        S_CAP_B = 3'd4,
        S_EXEC  = 3'd5,
        S_WR    = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational ALU: optional zero/negate of each operand, add or AND,
// optional negate of the result, plus zero/negative flags.
module alu
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = ctrl[CTRL_ZX] ? '0 : x;
        x_n   = ctrl[CTRL_NX] ? ~x_z : x_z;
        y_z   = ctrl[CTRL_ZY] ? '0 : y;
        y_n   = ctrl[CTRL_NY] ? ~y_z : y_z;
        // sum wraps at DATA_W bits; carry out is dropped on purpose
        f_out = ctrl[CTRL_F] ? (x_n + y_n) : (x_n & y_n);
        out   = ctrl[CTRL_NO] ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[DATA_W-1];
    end

endmodule

// File: rtl/alu_seq.sv
// Sequencer that reads two operands from external RAM, runs them through
// the ALU and writes the result back, one command every 8 cycles.
//
// state   | meaning
// IDLE    | ready for a command, latches it on cmd_valid
// RD_A    | present src_a address to RAM
// CAP_A   | hold src_a address, capture x operand at end of cycle
// RD_B    | present src_b address to RAM
// CAP_B   | hold src_b address, capture y operand at end of cycle
// EXEC    | ALU evaluates, result and flags registered
// WR      | write result to dst (single-cycle write strobe)
// DONE    | one-cycle completion pulse
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CTRL_W-1:0] cmd_ctrl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res_out,
    output logic              res_zr,
    output logic              res_ng
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] x_reg, y_reg;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr, alu_ng;

    alu #(.DATA_W(DATA_W)) u_alu (
        .x    (x_reg),
        .y    (y_reg),
        .ctrl (ctrl_q),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            ctrl_q  <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            res_out <= '0;
            res_zr  <= 1'b0;
            res_ng  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid) begin
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                dst_q   <= cmd_dst;
                ctrl_q  <= cmd_ctrl;
            end
            // capturing at the end of the second read cycle covers both
            // combinational and one-cycle-registered RAM reads
            if (state_q == S_CAP_A) x_reg <= mem_rdata;
            if (state_q == S_CAP_B) y_reg <= mem_rdata;
            if (state_q == S_EXEC) begin
                res_out <= alu_out;
                res_zr  <= alu_zr;
                res_ng  <= alu_ng;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_addr  = '0;
        mem_rw    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = S_RD_A;
            end
            S_RD_A: begin
                mem_addr = src_a_q;
                state_d  = S_CAP_A;
            end
            S_CAP_A: begin
                mem_addr = src_a_q;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                mem_addr = src_b_q;
                state_d  = S_CAP_B;
            end
            S_CAP_B: begin
                mem_addr = src_b_q;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WR;
            end
            S_WR: begin
                mem_addr  = dst_q;
                mem_rw    = 1'b1;
                mem_wdata = res_out;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
